// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its 2-way arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  localparam int IDX_ALU = 0;
  localparam int IDX_LSU = 1;

  localparam logic [RF_ADDR_W-1:0] CLEAR_FIRST = RF_ADDR_W'(1);
  localparam logic [RF_ADDR_W-1:0] CLEAR_LAST  = RF_ADDR_W'(RF_DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_LSU : REQ_ALU;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer flips only on contention.
module rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  req_id_e r_ptr;
  logic    w_contend;

  // Grant the lone requester, or the pointer's favourite when both ask.
  always_comb begin
    w_contend = i_valid[IDX_ALU] & i_valid[IDX_LSU];
    o_grant   = i_valid;
    if (w_contend) begin
      o_grant = (r_ptr == REQ_LSU) ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the loser after every contended grant; uncontended grants leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= REQ_LSU;
    end else if (w_contend) begin
      r_ptr <= other_req(r_ptr);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: optional x1..x31 clear after reset, then ALU/LSU round-robin writes.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  input  logic [RF_ADDR_W-1:0] alu_addr_i,
  input  logic [RF_DATA_W-1:0] alu_data_i,
  output logic                 alu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [RF_ADDR_W-1:0] lsu_addr_i,
  input  logic [RF_DATA_W-1:0] lsu_data_i,
  output logic                 lsu_ready_o,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [RF_DATA_W-1:0] rf_wdata_o,
  output logic                 busy_o
);

  localparam state_e RESET_STATE = INIT_CLEAR ? INIT : RUN;

  state_e               r_state;
  state_e               w_state_next;
  logic [RF_ADDR_W-1:0] r_cnt;
  logic                 w_busy;
  logic                 w_run;
  logic [1:0]           w_arb_valid;
  logic [1:0]           w_grant;
  logic                 w_acc;
  logic [RF_ADDR_W-1:0] w_sel_addr;
  logic [RF_DATA_W-1:0] w_sel_data;
  logic                 r_we;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [RF_DATA_W-1:0] r_wdata;

  // State register; reset lands in the clear sequence only when it is enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leave the clear once the last register address has been issued.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == INIT) && (r_cnt == CLEAR_LAST)) begin
      w_state_next = RUN;
    end
  end

  // Busy flag and arbiter enable follow directly from the state.
  always_comb begin
    w_busy = (r_state == INIT);
    w_run  = (r_state == RUN);
  end

  // Clear address counter, stepping once per cycle while clearing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= CLEAR_FIRST;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + RF_ADDR_W'(1);
    end
  end

  assign w_arb_valid = {lsu_valid_i & w_run, alu_valid_i & w_run};

  rr_arb2 u_rr_arb2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_valid (w_arb_valid),
    .o_grant (w_grant)
  );

  // Mux the granted requester onto the write path.
  always_comb begin
    w_acc      = |w_grant;
    w_sel_addr = '0;
    w_sel_data = '0;
    if (w_grant[IDX_ALU]) begin
      w_sel_addr = alu_addr_i;
      w_sel_data = alu_data_i;
    end else if (w_grant[IDX_LSU]) begin
      w_sel_addr = lsu_addr_i;
      w_sel_data = lsu_data_i;
    end
  end

  // Registered write port; x0 writes are accepted but never asserted on the port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (r_state == INIT) begin
      r_we    <= 1'b1;
      r_waddr <= r_cnt;
      r_wdata <= '0;
    end else if (w_acc) begin
      r_we    <= |w_sel_addr;
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign alu_ready_o = w_grant[IDX_ALU];
  assign lsu_ready_o = w_grant[IDX_LSU];
  assign rf_we_o     = r_we;
  assign rf_waddr_o  = r_waddr;
  assign rf_wdata_o  = r_wdata;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rstN;
  logic        aluValid, lsuValid;
  logic [4:0]  aluAddr, lsuAddr;
  logic [31:0] aluData, lsuData;
  logic        aluReady, lsuReady, rfWe, busy;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;

  logic        rst0N;
  logic        a0Valid, l0Valid;
  logic [4:0]  a0Addr, l0Addr;
  logic [31:0] a0Data, l0Data;
  logic        a0Ready, l0Ready, rfWe0, busy0;
  logic [4:0]  rfWaddr0;
  logic [31:0] rfWdata0;

  int vecCount = 0;
  int errCount = 0;

  int          initLeft;
  bit          favorLsu;
  bit          expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  bit          lastAluReady, lastLsuReady;

  logic        holdA = 1'b0, holdL = 1'b0;
  logic [36:0] prevA, prevL;

  rf_wb_arbiter #(.INIT_CLEAR(1'b1)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .alu_valid_i(aluValid), .alu_addr_i(aluAddr), .alu_data_i(aluData), .alu_ready_o(aluReady),
    .lsu_valid_i(lsuValid), .lsu_addr_i(lsuAddr), .lsu_data_i(lsuData), .lsu_ready_o(lsuReady),
    .rf_we_o(rfWe), .rf_waddr_o(rfWaddr), .rf_wdata_o(rfWdata), .busy_o(busy)
  );

  rf_wb_arbiter #(.INIT_CLEAR(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst0N),
    .alu_valid_i(a0Valid), .alu_addr_i(a0Addr), .alu_data_i(a0Data), .alu_ready_o(a0Ready),
    .lsu_valid_i(l0Valid), .lsu_addr_i(l0Addr), .lsu_data_i(l0Data), .lsu_ready_o(l0Ready),
    .rf_we_o(rfWe0), .rf_waddr_o(rfWaddr0), .rf_wdata_o(rfWdata0), .busy_o(busy0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester obligation: an unserved request must stay put until it is accepted.
  always @(negedge clk) begin
    if (!rstN) begin
      holdA <= 1'b0;
      holdL <= 1'b0;
    end else begin
      if (holdA) assert (aluValid && ({aluAddr, aluData} == prevA))
        else $error("[TB] ALU requester changed a pending request");
      if (holdL) assert (lsuValid && ({lsuAddr, lsuData} == prevL))
        else $error("[TB] LSU requester changed a pending request");
      holdA <= aluValid && !aluReady;
      holdL <= lsuValid && !lsuReady;
      prevA <= {aluAddr, aluData};
      prevL <= {lsuAddr, lsuData};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    initLeft = 31;
    favorLsu = 1'b1;
    expWe    = 1'b0;
    expAddr  = '0;
    expData  = '0;
  endtask

  // Entered at posedge+1; asserts reset mid-cycle, checks the asynchronous clear, releases after two edges.
  task automatic resetDut1();
    rstN     = 1'b0;
    aluValid = 1'b0; aluAddr = '0; aluData = '0;
    lsuValid = 1'b0; lsuAddr = '0; lsuData = '0;
    #1;
    checkOutput("rst_we",        {31'b0, rfWe},     32'd0);
    checkOutput("rst_waddr",     {27'b0, rfWaddr},  32'd0);
    checkOutput("rst_wdata",     rfWdata,           32'd0);
    checkOutput("rst_busy",      {31'b0, busy},     32'd1);
    checkOutput("rst_alu_ready", {31'b0, aluReady}, 32'd0);
    checkOutput("rst_lsu_ready", {31'b0, lsuReady}, 32'd0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  // One clock cycle of stimulus for the main DUT, checked against the behavioural model.
  task automatic applyStimulus(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                               input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit          gA, gL, nWe;
    logic [4:0]  nAddr;
    logic [31:0] nData;
    aluValid = av; aluAddr = aa; aluData = ad;
    lsuValid = lv; lsuAddr = la; lsuData = ld;
    @(negedge clk);
    gA = 1'b0;
    gL = 1'b0;
    if (initLeft == 0) begin
      if (av && lv) begin
        if (favorLsu) gL = 1'b1;
        else          gA = 1'b1;
        favorLsu = !favorLsu;
      end else begin
        gA = av;
        gL = lv;
      end
    end
    checkOutput("alu_ready", {31'b0, aluReady}, {31'b0, gA});
    checkOutput("lsu_ready", {31'b0, lsuReady}, {31'b0, gL});
    checkOutput("busy",      {31'b0, busy},     {31'b0, (initLeft > 0)});
    checkOutput("rf_we",     {31'b0, rfWe},     {31'b0, expWe});
    if (expWe) begin
      checkOutput("rf_waddr", {27'b0, rfWaddr}, {27'b0, expAddr});
      checkOutput("rf_wdata", rfWdata,          expData);
    end
    lastAluReady = aluReady;
    lastLsuReady = lsuReady;
    nWe = 1'b0; nAddr = '0; nData = '0;
    if (initLeft > 0) begin
      nWe      = 1'b1;
      nAddr    = 5'(32 - initLeft);
      initLeft = initLeft - 1;
    end else if (gA) begin
      nWe = (aa != 5'd0); nAddr = aa; nData = ad;
    end else if (gL) begin
      nWe = (la != 5'd0); nAddr = la; nData = ld;
    end
    @(posedge clk);
    #1;
    expWe   = nWe;
    expAddr = nAddr;
    expData = nData;
  endtask

  // Test sequence.
  initial begin
    bit          cAV, cLV;
    logic [4:0]  cAA, cLA;
    logic [31:0] cAD, cLD;

    rstN  = 1'b0;
    rst0N = 1'b0;
    aluValid = 1'b0; aluAddr = '0; aluData = '0;
    lsuValid = 1'b0; lsuAddr = '0; lsuData = '0;
    a0Valid = 1'b0; a0Addr = '0; a0Data = '0;
    l0Valid = 1'b0; l0Addr = '0; l0Data = '0;
    lastAluReady = 1'b0;
    lastLsuReady = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    $display("[TB] clear sequence with ALU request held pending");
    resetDut1();
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);

    $display("[TB] contention from reset pointer");
    applyStimulus(1'b1, 5'd7,  32'hA1A1A1A1, 1'b1, 5'd8,  32'hB1B1B1B1);
    applyStimulus(1'b1, 5'd7,  32'hA1A1A1A1, 1'b1, 5'd9,  32'hB2B2B2B2);
    applyStimulus(1'b1, 5'd10, 32'hA3A3A3A3, 1'b1, 5'd9,  32'hB2B2B2B2);
    applyStimulus(1'b1, 5'd10, 32'hA3A3A3A3, 1'b1, 5'd11, 32'hB4B4B4B4);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd11, 32'hB4B4B4B4);

    $display("[TB] LSU write to x0");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h00001234);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

    $display("[TB] randomized traffic");
    cAV = 1'b0; cLV = 1'b0;
    cAA = '0; cLA = '0; cAD = '0; cLD = '0;
    for (int i = 0; i < 300; i++) begin
      if (!(cAV && !lastAluReady)) begin
        cAV = ($urandom_range(0, 3) != 0);
        cAA = 5'($urandom);
        cAD = $urandom;
      end
      if (!(cLV && !lastLsuReady)) begin
        cLV = ($urandom_range(0, 3) != 0);
        cLA = 5'($urandom);
        cLD = $urandom;
      end
      applyStimulus(cAV, cAA, cAD, cLV, cLA, cLD);
    end

    $display("[TB] reset in the middle of the clear");
    resetDut1();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    resetDut1();
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);

    $display("[TB] no-clear instance, reset discards pending write");
    rst0N = 1'b1;
    a0Valid = 1'b1; a0Addr = 5'd3; a0Data = 32'hCAFEF00D;
    #1;
    checkOutput("d0_busy",      {31'b0, busy0},   32'd0);
    checkOutput("d0_alu_ready", {31'b0, a0Ready}, 32'd1);
    checkOutput("d0_lsu_ready", {31'b0, l0Ready}, 32'd0);
    checkOutput("d0_we_idle",   {31'b0, rfWe0},   32'd0);
    @(posedge clk);
    #1;
    checkOutput("d0_we",    {31'b0, rfWe0},    32'd1);
    checkOutput("d0_waddr", {27'b0, rfWaddr0}, 32'd3);
    checkOutput("d0_wdata", rfWdata0,          32'hCAFEF00D);
    a0Addr = 5'd4; a0Data = 32'h0BADCAFE;
    @(negedge clk);
    checkOutput("d0_alu_ready2", {31'b0, a0Ready}, 32'd1);
    rst0N = 1'b0;
    #1;
    checkOutput("d0_rst_we",    {31'b0, rfWe0},    32'd0);
    checkOutput("d0_rst_waddr", {27'b0, rfWaddr0}, 32'd0);
    checkOutput("d0_rst_wdata", rfWdata0,          32'd0);
    checkOutput("d0_rst_busy",  {31'b0, busy0},    32'd0);
    @(posedge clk);
    #1;
    checkOutput("d0_discard_we", {31'b0, rfWe0}, 32'd0);
    a0Addr = 5'd6; a0Data = 32'h0000600D;
    @(posedge clk);
    #1;
    rst0N = 1'b1;
    #1;
    checkOutput("d0_rel_ready", {31'b0, a0Ready}, 32'd1);
    checkOutput("d0_rel_busy",  {31'b0, busy0},   32'd0);
    @(posedge clk);
    #1;
    checkOutput("d0_rel_we",    {31'b0, rfWe0},    32'd1);
    checkOutput("d0_rel_waddr", {27'b0, rfWaddr0}, 32'd6);
    checkOutput("d0_rel_wdata", rfWdata0,          32'h0000600D);
    a0Valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("d0_idle_we", {31'b0, rfWe0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
